// File: rtl/inv_quant.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// inv_quant
// Inverse quantiser for one transform block.  A start pulse captures the
// block's QP, component and transform size; the effective QP is then split
// into a period (qpe/6) and a remainder (qpe%6) by repeated subtraction.
// After that, four coefficient levels per beat are scaled through a fixed
// three-stage pipeline and saturated to 16 bits.
//
// Ports
//   clk      in   1   rising-edge clock
//   rstn     in   1   asynchronous active-low reset
//   start_i  in   1   launches a block (only honoured in IDLE)
//   qp_i     in   6   luma QP, values above 51 treated as 51
//   sel_i    in   2   component select, `TYPE_Y = luma, otherwise chroma
//   size_i   in   2   transform size 4x4/8x8/16x16/32x32
//   val_i    in   1   input beat valid
//   coef_i   in  64   four signed 16-bit levels, lane 0 in [15:0]
//   rdy_o    out  1   ready to accept beats
//   val_o    out  1   output beat valid
//   coef_o   out 64   four signed 16-bit reconstructed coefficients
//   done_o   out  1   marks the last output beat of the block
// ---------------------------------------------------------------------------
`ifndef TYPE_Y
`define TYPE_Y 2'b00
`endif

module inv_quant (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [5:0]  qp_i,
    input  logic [1:0]  sel_i,
    input  logic [1:0]  size_i,
    input  logic        val_i,
    input  logic [63:0] coef_i,
    output logic        rdy_o,
    output logic        val_o,
    output logic [63:0] coef_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  size_r;
    logic [3:0]  per_r;
    logic [5:0]  rem_r;
    logic [8:0]  cnt;

    logic [5:0]  qp_clamped;
    logic [5:0]  qpe_in;
    logic [8:0]  beat_last_idx;
    logic        accept;
    logic        last_beat;
    logic [6:0]  scale;

    // Pipeline registers and their combinational feeds
    logic               v1, v2;
    logic               last1, last2;
    logic signed [23:0] prod [4];
    logic signed [23:0] p1   [4];
    logic signed [39:0] wide [4];
    logic signed [39:0] s2   [4];
    logic signed [39:0] shifted [4];
    logic [63:0]        clip_bus;
    logic [4:0]         up_shift;
    logic [2:0]         rnd_pos;
    logic [2:0]         down_shift;
    logic signed [39:0] rnd;

    // Chroma QP mapping; the middle band follows a compressed table.
    function automatic logic [5:0] chroma_qp(input logic [5:0] q);
        logic [5:0] r;
        r = q - 6'd6;
        if (q < 6'd30) begin
            r = q;
        end else begin
            case (q)
                6'd30:   r = 6'd29;
                6'd31:   r = 6'd30;
                6'd32:   r = 6'd31;
                6'd33:   r = 6'd32;
                6'd34:   r = 6'd33;
                6'd35:   r = 6'd33;
                6'd36:   r = 6'd34;
                6'd37:   r = 6'd34;
                6'd38:   r = 6'd35;
                6'd39:   r = 6'd35;
                6'd40:   r = 6'd36;
                6'd41:   r = 6'd36;
                6'd42:   r = 6'd37;
                6'd43:   r = 6'd37;
                default: r = q - 6'd6;
            endcase
        end
        return r;
    endfunction

    // The effective QP is formed on the start cycle and parked in rem_r so
    // that LOAD only has to peel off sixes from it.
    assign qp_clamped    = (qp_i > 6'd51) ? 6'd51 : qp_i;
    assign qpe_in        = (sel_i == `TYPE_Y) ? qp_clamped : chroma_qp(qp_clamped);
    assign beat_last_idx = (9'd4 << {size_r, 1'b0}) - 9'd1;
    assign accept        = (state == BUSY) && val_i;
    assign last_beat     = accept && (cnt == beat_last_idx);
    assign rdy_o         = (state == BUSY);

    // Next-state logic; DRAIN waits for the last beat to leave the pipeline.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)           state_nxt = LOAD;
            LOAD:    if (rem_r < 6'd6)      state_nxt = BUSY;
            BUSY:    if (last_beat)         state_nxt = DRAIN;
            DRAIN:   if (done_o)            state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // State register plus per-block control: capture, QP division, beat count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            size_r <= 2'd0;
            per_r  <= 4'd0;
            rem_r  <= 6'd0;
            cnt    <= 9'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        size_r <= size_i;
                        per_r  <= 4'd0;
                        rem_r  <= qpe_in;
                        cnt    <= 9'd0;
                    end
                end
                LOAD: begin
                    if (rem_r >= 6'd6) begin
                        rem_r <= rem_r - 6'd6;
                        per_r <= per_r + 4'd1;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        cnt <= cnt + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Level scale selected by the QP remainder.
    always_comb begin
        scale = 7'd40;
        case (rem_r)
            6'd0:    scale = 7'd40;
            6'd1:    scale = 7'd45;
            6'd2:    scale = 7'd51;
            6'd3:    scale = 7'd57;
            6'd4:    scale = 7'd64;
            6'd5:    scale = 7'd72;
            default: scale = 7'd40;
        endcase
    end

    // Stage arithmetic: multiply by scale, then shift up by per+4 (the x16
    // folds into the shift) and add the rounding term, then shift down by
    // the block's bit depth and saturate.  40 bits hold the worst case of
    // a full-scale level at per 8 without wrapping.
    assign up_shift   = {1'b0, per_r} + 5'd4;
    assign rnd_pos    = {1'b0, size_r} + 3'd4;
    assign down_shift = {1'b0, size_r} + 3'd5;
    assign rnd        = 40'sd1 <<< rnd_pos;

    always_comb begin
        clip_bus = 64'd0;
        for (int i = 0; i < 4; i++) begin
            prod[i]    = $signed(coef_i[16*i +: 16]) * $signed({1'b0, scale});
            wide[i]    = ($signed({{16{p1[i][23]}}, p1[i]}) <<< up_shift) + rnd;
            shifted[i] = s2[i] >>> down_shift;
            if (shifted[i] > 40'sd32767) begin
                clip_bus[16*i +: 16] = 16'h7fff;
            end else if (shifted[i] < -40'sd32768) begin
                clip_bus[16*i +: 16] = 16'h8000;
            end else begin
                clip_bus[16*i +: 16] = shifted[i][15:0];
            end
        end
    end

    // Three-stage datapath; valids always advance, data only moves with a
    // valid so coef_o holds its last value through gaps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            last1  <= 1'b0;
            last2  <= 1'b0;
            val_o  <= 1'b0;
            done_o <= 1'b0;
            coef_o <= 64'd0;
            for (int i = 0; i < 4; i++) begin
                p1[i] <= 24'sd0;
                s2[i] <= 40'sd0;
            end
        end else begin
            v1     <= accept;
            last1  <= last_beat;
            v2     <= v1;
            last2  <= last1;
            val_o  <= v2;
            done_o <= v2 && last2;
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    p1[i] <= prod[i];
                end
            end
            if (v1) begin
                for (int i = 0; i < 4; i++) begin
                    s2[i] <= wide[i];
                end
            end
            if (v2) begin
                coef_o <= clip_bus;
            end
        end
    end

endmodule

// File: tb/tb_inv_quant.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_inv_quant
// Self-checking bench for inv_quant.  Beats are driven on the falling edge,
// outputs are sampled on the falling edge, and every accepted beat is scored
// against an integer reference model built from the scaling rules.
// ---------------------------------------------------------------------------
`ifndef TYPE_Y
`define TYPE_Y 2'b00
`endif

module tb_inv_quant;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  qp_i = 6'd0;
    logic [1:0]  sel_i = 2'd0;
    logic [1:0]  size_i = 2'd0;
    logic        val_i = 1'b0;
    logic [63:0] coef_i = 64'd0;
    logic        rdy_o;
    logic        val_o;
    logic [63:0] coef_o;
    logic        done_o;

    inv_quant dut (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (start_i),
        .qp_i    (qp_i),
        .sel_i   (sel_i),
        .size_i  (size_i),
        .val_i   (val_i),
        .coef_i  (coef_i),
        .rdy_o   (rdy_o),
        .val_o   (val_o),
        .coef_o  (coef_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    int          exp_cyc[$];
    logic [63:0] exp_coef[$];
    bit          exp_last[$];
    int          obs_cyc[$];
    logic [63:0] obs_coef[$];
    bit          obs_done[$];
    int          done_cnt = 0;
    int          load_cycles;
    bit          drive_ok;

    // Output monitor
    always @(negedge clk) begin
        if (val_o === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_coef.push_back(coef_o);
            obs_done.push_back(done_o);
        end
        if (done_o === 1'b1) done_cnt++;
    end

    // Reference model
    function automatic int qpe_of(input int qp, input logic [1:0] sel);
        int q;
        int tbl[14];
        tbl = '{29, 30, 31, 32, 33, 33, 34, 34, 35, 35, 36, 36, 37, 37};
        q = (qp > 51) ? 51 : qp;
        if (sel == `TYPE_Y || q < 30) return q;
        if (q <= 43) return tbl[q - 30];
        return q - 6;
    endfunction

    function automatic logic [15:0] model_lane(input logic [15:0] c, input int qp,
                                               input logic [1:0] sel, input int size);
        int     qpe, per, rem;
        int     scales[6];
        longint v;
        scales = '{40, 45, 51, 57, 64, 72};
        qpe = qpe_of(qp, sel);
        per = qpe / 6;
        rem = qpe % 6;
        v = longint'($signed(c)) * scales[rem] * 16;
        v = v * (longint'(1) << per);
        v = v + (longint'(1) << (size + 4));
        v = v >>> (size + 5);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [63:0] model_beat(input logic [63:0] b, input int qp,
                                               input logic [1:0] sel, input int size);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = model_lane(b[16*i +: 16], qp, sel, size);
        return r;
    endfunction

    // Drives one block: start pulse, LOAD measurement, beats with optional
    // gaps, an optional ignored mid-block start, and junk beats during DRAIN.
    task automatic applyStimulus(input int qp, input logic [1:0] sel, input int size,
                                 input int gap_pct, input bit use_fixed,
                                 input logic [63:0] fixed, input bit mid_start,
                                 input int stop_after);
        int          n, acc, guard;
        bit          v, mid_done;
        logic [63:0] beat;
        exp_cyc.delete(); exp_coef.delete(); exp_last.delete();
        obs_cyc.delete(); obs_coef.delete(); obs_done.delete();
        done_cnt = 0;
        drive_ok = 1'b1;
        mid_done = 1'b0;
        n = 4 << (2 * size);
        @(negedge clk);
        start_i = 1'b1; qp_i = qp[5:0]; sel_i = sel; size_i = size[1:0];
        @(negedge clk);
        start_i = 1'b0; qp_i = 6'($urandom); sel_i = 2'($urandom); size_i = 2'($urandom);
        load_cycles = 0;
        while (rdy_o !== 1'b1 && load_cycles < 100) begin
            load_cycles++;
            @(negedge clk);
        end
        if (load_cycles >= 100) begin
            total++; bad++;
            $display("[TB] FAIL load_timeout: rdy_o never rose, got %0d cycles, need <100", load_cycles);
            drive_ok = 1'b0;
            return;
        end
        acc = 0;
        guard = 0;
        while (acc < n && guard < 20 * n + 100) begin
            v = ($urandom_range(99) >= gap_pct);
            beat = use_fixed ? fixed : {$urandom, $urandom};
            val_i = v;
            coef_i = beat;
            start_i = 1'b0;
            if (mid_start && !mid_done && acc == n / 2) begin
                start_i = 1'b1; qp_i = 6'd0; sel_i = `TYPE_Y; size_i = 2'd0;
                mid_done = 1'b1;
            end
            if (v && rdy_o === 1'b1) begin
                exp_cyc.push_back(cyc);
                exp_coef.push_back(model_beat(beat, qp, sel, size));
                acc++;
                exp_last.push_back(acc == n);
            end
            guard++;
            @(negedge clk);
            if (stop_after > 0 && acc == stop_after) begin
                start_i = 1'b0;
                return;
            end
        end
        start_i = 1'b0;
        if (acc < n) begin
            total++; bad++;
            $display("[TB] FAIL beat_timeout: accepted %0d beats, need %0d", acc, n);
            drive_ok = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            val_i = 1'b1; coef_i = {$urandom, $urandom};
            @(negedge clk);
        end
        val_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({rdy_o, val_o, done_o} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: rdy/val/done=%b need 000", {rdy_o, val_o, done_o});
        end
        total++;
        if (coef_o !== 64'd0) begin
            bad++;
            $display("[TB] FAIL reset_coef: coef_o=%h need 0", coef_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (rdy_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_rdy: rdy_o=%b need 0", rdy_o);
        end
    endtask

    task automatic test_luma_basic();
        applyStimulus(0, `TYPE_Y, 0, 0, 1'b1, {4{16'd1}}, 1'b0, 0);
        if (!drive_ok) return;
        total++;
        if (load_cycles != 1) begin
            bad++; $display("[TB] FAIL luma_load: %0d cycles need 1", load_cycles);
        end
        total++;
        if (obs_coef.size() < 1 || obs_coef[0] !== {4{16'd20}}) begin
            bad++; $display("[TB] FAIL luma_value: got %h need %h", obs_coef.size() ? obs_coef[0] : 64'hx, {4{16'd20}});
        end
        total++;
        if (obs_cyc.size() != exp_cyc.size() || done_cnt != 1) begin
            bad++; $display("[TB] FAIL luma_count: beats=%0d done=%0d need %0d and 1", obs_cyc.size(), done_cnt, exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            total++;
            if (obs_coef[i] !== exp_coef[i] || obs_cyc[i] != exp_cyc[i] + 3 || obs_done[i] !== exp_last[i]) begin
                bad++; $display("[TB] FAIL luma_beat%0d: got %h@%0d done=%b need %h@%0d done=%b", i, obs_coef[i], obs_cyc[i], obs_done[i], exp_coef[i], exp_cyc[i] + 3, exp_last[i]);
            end
        end
    endtask

    task automatic test_chroma_load();
        applyStimulus(37, 2'd1, 1, 0, 1'b1, {4{-16'sd3}}, 1'b0, 0);
        if (!drive_ok) return;
        total++;
        if (load_cycles != 6) begin
            bad++; $display("[TB] FAIL chroma_load: %0d cycles need 6", load_cycles);
        end
        total++;
        if (obs_coef.size() < 1 || obs_coef[0] !== {4{16'hfa00}}) begin
            bad++; $display("[TB] FAIL chroma_value: got %h need %h", obs_coef.size() ? obs_coef[0] : 64'hx, {4{16'hfa00}});
        end
        total++;
        if (obs_cyc.size() != exp_cyc.size() || done_cnt != 1) begin
            bad++; $display("[TB] FAIL chroma_count: beats=%0d done=%0d need %0d and 1", obs_cyc.size(), done_cnt, exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            total++;
            if (obs_coef[i] !== exp_coef[i] || obs_cyc[i] != exp_cyc[i] + 3 || obs_done[i] !== exp_last[i]) begin
                bad++; $display("[TB] FAIL chroma_beat%0d: got %h@%0d done=%b need %h@%0d done=%b", i, obs_coef[i], obs_cyc[i], obs_done[i], exp_coef[i], exp_cyc[i] + 3, exp_last[i]);
            end
        end
    endtask

    task automatic test_saturation();
        applyStimulus(60, `TYPE_Y, 3, 0, 1'b1, 64'h8000_7fff_8000_7fff, 1'b0, 0);
        if (!drive_ok) return;
        total++;
        if (load_cycles != 9) begin
            bad++; $display("[TB] FAIL sat_load: %0d cycles need 9", load_cycles);
        end
        total++;
        if (obs_coef.size() < 1 || obs_coef[obs_coef.size() - 1] !== 64'h8000_7fff_8000_7fff) begin
            bad++; $display("[TB] FAIL sat_value: got %h need 80007fff80007fff", obs_coef.size() ? obs_coef[obs_coef.size() - 1] : 64'hx);
        end
        total++;
        if (obs_cyc.size() != 256 || done_cnt != 1) begin
            bad++; $display("[TB] FAIL sat_count: beats=%0d done=%0d need 256 and 1", obs_cyc.size(), done_cnt);
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            total++;
            if (obs_coef[i] !== exp_coef[i] || obs_cyc[i] != exp_cyc[i] + 3 || obs_done[i] !== exp_last[i]) begin
                bad++; $display("[TB] FAIL sat_beat%0d: got %h@%0d done=%b need %h@%0d done=%b", i, obs_coef[i], obs_cyc[i], obs_done[i], exp_coef[i], exp_cyc[i] + 3, exp_last[i]);
            end
        end
    endtask

    task automatic test_gaps_midstart();
        applyStimulus(50, 2'd2, 2, 35, 1'b0, 64'd0, 1'b1, 0);
        if (!drive_ok) return;
        total++;
        if (load_cycles != 8) begin
            bad++; $display("[TB] FAIL gap_load: %0d cycles need 8", load_cycles);
        end
        total++;
        if (obs_cyc.size() != 64 || done_cnt != 1) begin
            bad++; $display("[TB] FAIL gap_count: beats=%0d done=%0d need 64 and 1", obs_cyc.size(), done_cnt);
        end
        total++;
        if (rdy_o !== 1'b0 || val_o !== 1'b0) begin
            bad++; $display("[TB] FAIL gap_idle: rdy=%b val=%b need 0 0", rdy_o, val_o);
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            total++;
            if (obs_coef[i] !== exp_coef[i] || obs_cyc[i] != exp_cyc[i] + 3 || obs_done[i] !== exp_last[i]) begin
                bad++; $display("[TB] FAIL gap_beat%0d: got %h@%0d done=%b need %h@%0d done=%b", i, obs_coef[i], obs_cyc[i], obs_done[i], exp_coef[i], exp_cyc[i] + 3, exp_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int qp, size;
        logic [1:0] sel;
        for (int b = 0; b < 6; b++) begin
            qp = $urandom_range(63);
            sel = 2'($urandom);
            size = $urandom_range(2);
            applyStimulus(qp, sel, size, 20, 1'b0, 64'd0, 1'b0, 0);
            if (!drive_ok) return;
            total++;
            if (load_cycles != qpe_of(qp, sel) / 6 + 1 || obs_cyc.size() != exp_cyc.size() || done_cnt != 1) begin
                bad++; $display("[TB] FAIL b2b%0d_ctrl: load=%0d beats=%0d done=%0d need %0d %0d 1", b, load_cycles, obs_cyc.size(), done_cnt, qpe_of(qp, sel) / 6 + 1, exp_cyc.size());
            end
            for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
                total++;
                if (obs_coef[i] !== exp_coef[i] || obs_cyc[i] != exp_cyc[i] + 3 || obs_done[i] !== exp_last[i]) begin
                    bad++; $display("[TB] FAIL b2b%0d_beat%0d: got %h@%0d done=%b need %h@%0d done=%b", b, i, obs_coef[i], obs_cyc[i], obs_done[i], exp_coef[i], exp_cyc[i] + 3, exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(30, `TYPE_Y, 2, 0, 1'b0, 64'd0, 1'b0, 10);
        if (!drive_ok) return;
        val_i = 1'b1;
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({rdy_o, val_o, done_o} !== 3'b000 || coef_o !== 64'd0) begin
            bad++; $display("[TB] FAIL rst_mid_outputs: rdy/val/done=%b coef=%h need 000 and 0", {rdy_o, val_o, done_o}, coef_o);
        end
        obs_cyc.delete(); obs_coef.delete(); obs_done.delete();
        done_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        val_i = 1'b0;
        total++;
        if (obs_cyc.size() != 0 || done_cnt != 0 || rdy_o !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_mid_quiet: beats=%0d done=%0d rdy=%b need 0 0 0", obs_cyc.size(), done_cnt, rdy_o);
        end
        applyStimulus(44, 2'd3, 2, 10, 1'b0, 64'd0, 1'b0, 0);
        if (!drive_ok) return;
        total++;
        if (load_cycles != 7 || obs_cyc.size() != 64 || done_cnt != 1) begin
            bad++; $display("[TB] FAIL rst_fresh_ctrl: load=%0d beats=%0d done=%0d need 7 64 1", load_cycles, obs_cyc.size(), done_cnt);
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            total++;
            if (obs_coef[i] !== exp_coef[i] || obs_cyc[i] != exp_cyc[i] + 3 || obs_done[i] !== exp_last[i]) begin
                bad++; $display("[TB] FAIL rst_fresh_beat%0d: got %h@%0d done=%b need %h@%0d done=%b", i, obs_coef[i], obs_cyc[i], obs_done[i], exp_coef[i], exp_cyc[i] + 3, exp_last[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_luma_basic();
        test_chroma_load();
        test_saturation();
        test_gaps_midstart();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
